// File: rtl/imem_loader_pkg.sv
// Shared types and width constants for the boot-time instruction loader.
// Imported by the byte packer and the loader top level.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        LEN,
        DATA,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian words from a byte stream; byte k lands in [8k+7:8k].
// The word is presented combinationally on the cycle its last byte arrives.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [BCNT_W-1:0] byte_cnt
);

    localparam int SH_W = WORD_W - BYTE_W;

    // Holds the three earlier bytes; the newest byte completes the word.
    logic [SH_W-1:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            byte_cnt <= '0;
        end else if (in_valid) begin
            sh       <= {in_data, sh[SH_W-1:BYTE_W]};
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign word_valid = in_valid && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign word       = {in_data, sh};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image from the UART into imem,
// holding the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TIMEOUT     = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_boot_en,
    input  logic              i_rx_valid,
    input  logic [BYTE_W-1:0] i_rx_data,
    output logic              o_we,
    output logic [31:0]       o_addr,
    output logic [WORD_W-1:0] o_data,
    output logic              o_cpu_resetn,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t state, state_nx;

    logic              pk_valid;
    logic              pk_word_valid;
    logic [WORD_W-1:0] pk_word;
    logic [BCNT_W-1:0] pk_cnt;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] len_q;
    logic [TMR_W-1:0] tmr;
    logic             running;
    logic             timeout_hit;
    logic             hdr_start;

    // Bytes are dropped once the loader has reached a terminal state.
    assign pk_valid = i_rx_valid && ((state == LEN) || (state == DATA));

    byte_packer u_packer (
        .clk        (i_clk),
        .rst_n      (i_resetn),
        .in_valid   (pk_valid),
        .in_data    (i_rx_data),
        .word_valid (pk_word_valid),
        .word       (pk_word),
        .byte_cnt   (pk_cnt)
    );

    assign idx_inc     = idx + 1'b1;
    assign running     = ((state == LEN) && (pk_cnt != '0)) || (state == DATA);
    assign timeout_hit = running && !i_rx_valid
                         && (tmr == TMR_W'(TIMEOUT - 1));
    assign hdr_start   = (state == LEN) && (state_nx == DATA);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= LEN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LEN: begin
                if ((pk_cnt == '0) && !i_boot_en) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = ERR;
                end else if (pk_word_valid) begin
                    if (pk_word == '0) begin
                        state_nx = DONE;
                    end else if (pk_word > WORD_W'(DEPTH_WORDS)) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (timeout_hit) begin
                    state_nx = ERR;
                end else if (pk_word_valid && (idx_inc == len_q)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = DONE;
            ERR:  state_nx = ERR;
            default: state_nx = ERR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            idx          <= '0;
            len_q        <= '0;
            tmr          <= '0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_cpu_resetn <= 1'b0;
        end else begin
            o_we         <= 1'b0;
            o_cpu_resetn <= (state == DONE);

            if (i_rx_valid || !running) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end

            if (hdr_start) begin
                len_q <= IDX_W'(pk_word);
                idx   <= '0;
            end

            if ((state == DATA) && pk_word_valid) begin
                o_we   <= 1'b1;
                o_data <= pk_word;
                o_addr <= BASE_ADDR + (32'(idx) << 2);
                idx    <= idx_inc;
            end
        end
    end

    assign o_busy = ((state == LEN) && (pk_cnt != '0)) || (state == DATA);
    assign o_done = (state == DONE);
    assign o_err  = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: images, header limits, timeout, reset, boot bypass.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_boot_en = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic        o_cpu_resetn;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_n  = 0;

    imem_loader #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .TIMEOUT     (16)
    ) dut (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_boot_en    (i_boot_en),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_cpu_resetn (o_cpu_resetn),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_we === 1'b1) wr_n++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic apply_reset(input logic boot);
        i_resetn   = 1'b0;
        i_rx_valid = 1'b0;
        i_boot_en  = boot;
        tick(2);
        i_resetn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick(1);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", o_we); end
        n_cmp++; if (o_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", o_addr); end
        n_cmp++; if (o_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", o_data); end
        n_cmp++; if ({o_cpu_resetn, o_busy, o_done, o_err} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_flags: got %b want 0000", {o_cpu_resetn, o_busy, o_done, o_err}); end
        tick(3);
        n_cmp++; if ({o_busy, o_done, o_err} !== 3'b000) begin
            n_bad++; $display("FAIL idle_wait: got %b want 000", {o_busy, o_done, o_err}); end
    endtask

    task automatic test_image();
        int base;
        apply_reset(1'b1);
        base = wr_n;
        send_word(32'd2);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL img_busy: got %b want 1", o_busy); end
        send_word(32'h0000_0093);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 32'h0, 32'h0000_0093}) begin
            n_bad++; $display("FAIL img_w0: got we=%b a=%h d=%h want 1 0 00000093", o_we, o_addr, o_data); end
        send_word(32'h0010_0113);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 32'h4, 32'h0010_0113}) begin
            n_bad++; $display("FAIL img_w1: got we=%b a=%h d=%h want 1 4 00100113", o_we, o_addr, o_data); end
        n_cmp++; if ({o_done, o_cpu_resetn} !== 2'b10) begin
            n_bad++; $display("FAIL img_c1: got done/cpu=%b want 10", {o_done, o_cpu_resetn}); end
        tick(1);
        n_cmp++; if ({o_we, o_done, o_cpu_resetn} !== 3'b011) begin
            n_bad++; $display("FAIL img_c2: got we/done/cpu=%b want 011", {o_we, o_done, o_cpu_resetn}); end
        send_word(32'hDEAD_BEEF);
        tick(2);
        n_cmp++; if (wr_n - base !== 2) begin n_bad++; $display("FAIL img_wr_cnt: got %0d want 2", wr_n - base); end
        i_resetn = 1'b0;
        #1;
        n_cmp++; if ({o_cpu_resetn, o_done} !== 2'b00) begin
            n_bad++; $display("FAIL img_async_rst: got cpu/done=%b want 00", {o_cpu_resetn, o_done}); end
        tick(1);
    endtask

    task automatic test_zero_len();
        int base;
        apply_reset(1'b1);
        base = wr_n;
        send_word(32'h0);
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", o_done); end
        tick(1);
        n_cmp++; if (o_cpu_resetn !== 1'b1) begin n_bad++; $display("FAIL zero_cpu: got %b want 1", o_cpu_resetn); end
        n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL zero_wr: got %0d want 0", wr_n - base); end
    endtask

    task automatic test_too_long();
        int base;
        apply_reset(1'b1);
        send_word(32'd1024);
        n_cmp++; if ({o_busy, o_err} !== 2'b10) begin
            n_bad++; $display("FAIL max_len: got busy/err=%b want 10", {o_busy, o_err}); end
        apply_reset(1'b1);
        base = wr_n;
        send_word(32'd1025);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL big_err: got %b want 1", o_err); end
        send_word(32'h1234_5678);
        tick(3);
        n_cmp++; if ({o_err, o_cpu_resetn, o_done} !== 3'b100) begin
            n_bad++; $display("FAIL big_sticky: got err/cpu/done=%b want 100", {o_err, o_cpu_resetn, o_done}); end
        n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL big_wr: got %0d want 0", wr_n - base); end
    endtask

    task automatic test_timeout();
        apply_reset(1'b1);
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        tick(15);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", o_err); end
        tick(1);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL to_fire: got %b want 1", o_err); end
        apply_reset(1'b1);
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        tick(15);
        send_byte(8'h33);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL to_byte_wins: got %b want 0", o_err); end
        tick(15);
        send_byte(8'h44);
        n_cmp++; if ({o_we, o_addr, o_data, o_err} !== {1'b1, 32'h0, 32'h4433_2211, 1'b0}) begin
            n_bad++; $display("FAIL to_word: got we=%b a=%h d=%h err=%b want 1 0 44332211 0",
                              o_we, o_addr, o_data, o_err); end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b1);
        send_word(32'd3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        i_resetn = 1'b0;
        #1;
        n_cmp++; if ({o_busy, o_we, o_err} !== 3'b000) begin
            n_bad++; $display("FAIL mid_async: got busy/we/err=%b want 000", {o_busy, o_we, o_err}); end
        tick(1);
        i_resetn = 1'b1;
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 32'h0, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL mid_reload: got we=%b a=%h d=%h want 1 0 cafef00d", o_we, o_addr, o_data); end
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL mid_done: got %b want 1", o_done); end
    endtask

    task automatic test_boot_dis();
        int base;
        apply_reset(1'b0);
        tick(1);
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL nb_done: got %b want 1", o_done); end
        tick(1);
        n_cmp++; if (o_cpu_resetn !== 1'b1) begin n_bad++; $display("FAIL nb_cpu: got %b want 1", o_cpu_resetn); end
        base = wr_n;
        i_boot_en = 1'b1;
        send_word(32'd1);
        send_word(32'h0000_0013);
        tick(2);
        n_cmp++; if (wr_n - base !== 0) begin n_bad++; $display("FAIL nb_wr: got %0d want 0", wr_n - base); end
        n_cmp++; if ({o_done, o_busy} !== 2'b10) begin
            n_bad++; $display("FAIL nb_state: got done/busy=%b want 10", {o_done, o_busy}); end
    endtask

    initial begin
        test_reset();
        test_image();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_reset_mid();
        test_boot_dis();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle CPU and its instruction memory. Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and issues one write per word into instruction memory. Holds the core in reset until the image is complete, then releases it. Also flags malformed or stalled transfers.

## Interface
- DEPTH_WORDS, 1024: instruction memory capacity in words; the upper bound on the image length.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- TIMEOUT, 1_000_000: maximum number of idle cycles allowed between bytes once a transfer has started.
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_resetn  in  1  asynchronous, active-low reset.
- i_boot_en  in  1  sampled while in LEN with zero bytes received; 0 → skip loading and go to DONE.
- i_rx_valid  in  1  one-cycle pulse per received byte; back-to-back pulses are legal.
- i_rx_data  in  8  byte qualified by i_rx_valid.
- o_we  out  1  instruction memory write strobe, one cycle per word.
- o_addr  out  32  byte address of the word being written.
- o_data  out  32  word being written.
- o_cpu_resetn  out  1  active-low reset to the core; registered.
- o_busy  out  1  high in LEN/DATA once the first byte has arrived.
- o_done  out  1  high in DONE.
- o_err  out  1  high in ERR; sticky.

## Operation
- Protocol: 4-byte little-endian word count N, followed by N words of 4 bytes each, every word little-endian.
- Byte k of a group (k=0..3) is placed in bits [8k+7:8k]. A 2-bit byte counter wraps 3→0.
- States:
  - LEN: assembling the count. On the 4th byte:
    - N=0 → DONE.
    - N>DEPTH_WORDS → ERR.
    - otherwise → DATA, with word index = 0.
  - DATA: assembling words.
    - On each 4th byte, register o_data = word, o_addr = BASE_ADDR + 4·index, set o_we, and increment index.
    - When the incremented index equals N, go to DONE in the same edge.
  - DONE: terminal; rx bytes are ignored.
  - ERR: terminal until reset; rx bytes are ignored.
- i_boot_en=0 while in LEN with byte counter = 0 → DONE; it is checked every cycle before the first byte arrives.
- Timeout:
  - The cycle counter clears on every i_rx_valid.
  - It runs only in LEN with byte counter ≠ 0, or in DATA.
  - Reaching TIMEOUT → ERR.
  - LEN with no bytes received waits indefinitely.
- Address arithmetic is 32-bit unsigned; index width is clog2(DEPTH_WORDS)+1.
- o_cpu_resetn = registered (state == DONE); it is never 1 in any other state.

## Timing
- Reset values: state LEN, counters 0, o_we=0, o_addr=0, o_data=0, o_cpu_resetn=0, o_busy=0, o_done=0, o_err=0.
- Write latency: 4th byte sampled at edge C → o_we=1 during cycle C+1, for exactly one cycle.
- For the last word:
  - state = DONE and o_done=1 from C+1.
  - o_cpu_resetn=1 from C+2, so the final write lands before the first fetch.
- ERR/DONE entry from the count (N=0, N too large) or from a timeout takes effect on the same edge; o_err/o_done rise in the following cycle.
- i_rx_valid on the same edge as a timeout expiry: the byte wins and the counter clears.
- Reset asserted mid-transfer:
  - all outputs return to reset values immediately (asynchronously);
  - any partial word is discarded;
  - o_cpu_resetn drops at once.

## Structure
- Package imem_loader_pkg holds:
  - the state enum: LEN, DATA, DONE, ERR;
  - the byte/word width constants (8, 32, 4 bytes per word).
- Sub-module byte_packer: shift-in register plus 2-bit byte counter, outputting a word_valid pulse and the assembled word. It is reused for both the count phase and the data phase.
- The top level holds the FSM, the index register, the timeout counter and the output registers.

## Test plan
- Image N=2, words 0x00000093 and 0x00100113 sent back-to-back:
  - o_we pulses at addr 0x0 data 0x00000093, then at addr 0x4 data 0x00100113;
  - o_done=1; o_cpu_resetn rises 2 cycles after the 4th byte of the last word.
- Count header 0x00000000 → DONE, no o_we pulse, o_cpu_resetn=1.
- DEPTH_WORDS=1024 with count 1025 → o_err=1 after the 4th header byte, no writes, o_cpu_resetn stays 0.
- TIMEOUT=16: send the header (N=1) plus 2 bytes, then go silent → o_err=1 exactly 16 cycles after the last byte; a byte arriving on the expiry cycle prevents the error.
- Assert i_resetn low after the 6th byte of a 3-word image, release, then resend a full image → the first write is at addr 0x0 with the new data, with no stale bytes mixed in.
- i_boot_en=0 at reset release → o_done=1 and o_cpu_resetn=1 without any rx traffic; subsequent rx bytes produce no o_we.
